// File: rtl/clock24_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock24_pkg
//  Description : Shared definitions for the 24-hour clock time-set path.
//                Holds the field widths and offsets of the packed
//                {hh, mm, ss, ms} time word, the field limits, the time-set
//                state encoding and the wrap-around step helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package clock24_pkg;

    // Field widths of the packed time word {hh, mm, ss, ms}
    localparam int HH_W   = 5;
    localparam int MM_W   = 6;
    localparam int SS_W   = 6;
    localparam int MS_W   = 10;
    localparam int TIME_W = HH_W + MM_W + SS_W + MS_W;

    // Bit offsets of each field's LSB inside the packed word
    localparam int MS_OFF = 0;
    localparam int SS_OFF = MS_OFF + MS_W;
    localparam int MM_OFF = SS_OFF + SS_W;
    localparam int HH_OFF = MM_OFF + MM_W;

    // Field limits: hours wrap at 23, minutes and seconds at 59
    localparam int HH_MAX = 23;
    localparam int MS_MAX = 59;

    // Time-set controller states. The low two bits of every edit state
    // equal the edit_field code reported for it (1 hh, 2 mm, 3 ss).
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_EDIT_HH = 3'd1,
        ST_EDIT_MM = 3'd2,
        ST_EDIT_SS = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

    // Increment with wrap to zero above the limit
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] lim);
        return (v >= lim) ? 6'd0 : v + 6'd1;
    endfunction

    // Decrement with wrap from zero to the limit
    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] lim);
        return (v == 6'd0) ? lim : v - 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_ctrl_if
//  Description : Button / clock-datapath bundle of the time-set controller.
//                master : button and live-time source, consumer of the load
//                slave  : the time-set controller itself
//  Signals     : btn_mode, btn_inc, btn_dec   button levels
//                cur_time                     live packed time
//                load, load_time              one-cycle preset into the clock
//                editing, edit_field, blink   display status
//  Revision    : 1.0  initial release
// ============================================================================
interface clock_set_ctrl_if;
    import clock24_pkg::*;

    logic              btn_mode;
    logic              btn_inc;
    logic              btn_dec;
    logic [TIME_W-1:0] cur_time;
    logic              load;
    logic [TIME_W-1:0] load_time;
    logic              editing;
    logic [1:0]        edit_field;
    logic              blink;

    modport master (
        output btn_mode, btn_inc, btn_dec, cur_time,
        input  load, load_time, editing, edit_field, blink
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec, cur_time,
        output load, load_time, editing, edit_field, blink
    );

endinterface
`default_nettype wire

// File: rtl/btn_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : btn_repeat
//  Description : Edge detect plus hold/auto-repeat for one button level.
//                step_o pulses for one cycle on the press, once more
//                HOLD_MS cycles after the press if still held, then every
//                RPT_MS cycles until release. clr_i restarts the hold timing
//                as if the button had just been pressed (without a step).
//  Ports       : kh_clk  clock          reset  async active-high reset
//                btn_i   button level   clr_i  restart hold/repeat timing
//                step_o  one-cycle step pulse (combinational from state)
//  Revision    : 1.0  initial release
// ============================================================================
module btn_repeat #(
    parameter int HOLD_MS = 500,
    parameter int RPT_MS  = 100,
    parameter int CNT_W   = 14
) (
    input  wire logic kh_clk,
    input  wire logic reset,
    input  wire logic btn_i,
    input  wire logic clr_i,
    output logic      step_o
);

    logic             prev_q;    // previous-cycle button level
    logic             active_q;  // a press has been seen and not yet released
    logic             rep_q;     // hold delay elapsed, now in repeat phase
    logic [CNT_W-1:0] cnt_q;     // cycles since press / last repeat step

    logic w_press;
    logic w_rep_hit;

    assign w_press   = btn_i & ~prev_q;
    assign w_rep_hit = btn_i & active_q &
                       (rep_q ? (cnt_q == CNT_W'(RPT_MS)) : (cnt_q == CNT_W'(HOLD_MS)));
    assign step_o    = w_press | w_rep_hit;

    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            // Reset to 1 so a button held through reset is not a press
            prev_q   <= 1'b1;
            active_q <= 1'b0;
            rep_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            prev_q <= btn_i;
            if (!btn_i) begin
                active_q <= 1'b0;
                rep_q    <= 1'b0;
                cnt_q    <= '0;
            end else if (w_press || clr_i) begin
                // The press edge is cycle 0, so the count starts at 1 next cycle
                active_q <= 1'b1;
                rep_q    <= 1'b0;
                cnt_q    <= CNT_W'(1);
            end else if (active_q) begin
                if (w_rep_hit) begin
                    rep_q <= 1'b1;
                    cnt_q <= CNT_W'(1);
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_ctrl
//  Description : Time-set controller for the 24-hour clock. Mode steps the
//                edit cursor RUN -> hh -> mm -> ss -> COMMIT; inc/dec adjust
//                the selected shadow field with wrap and auto-repeat. COMMIT
//                issues a one-cycle load of {shadow, 0 ms}. An idle edit
//                session times out back to RUN without loading.
//  Ports       : kh_clk  1 kHz clock    reset  async active-high reset
//                bus     clock_set_ctrl_if.slave (buttons, live time,
//                        load strobe/time, editing/edit_field/blink)
//  Revision    : 1.0  initial release
// ============================================================================
module clock_set_ctrl
    import clock24_pkg::*;
#(
    parameter int HOLD_MS    = 500,
    parameter int RPT_MS     = 100,
    parameter int TIMEOUT_MS = 10000,
    parameter int BLINK_MS   = 250
) (
    input  wire logic       kh_clk,
    input  wire logic       reset,
    clock_set_ctrl_if.slave bus
);

    // One counter width sized for the largest timing parameter
    localparam int MAX_AB = (HOLD_MS > RPT_MS) ? HOLD_MS : RPT_MS;
    localparam int MAX_CD = (TIMEOUT_MS > BLINK_MS) ? TIMEOUT_MS : BLINK_MS;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    state_t            state_q,      state_d;
    logic [HH_W-1:0]   hh_q,         hh_d;
    logic [MM_W-1:0]   mm_q,         mm_d;
    logic [SS_W-1:0]   ss_q,         ss_d;
    logic [CNT_W-1:0]  idle_q,       idle_d;
    logic [CNT_W-1:0]  bcnt_q,       bcnt_d;
    logic              blink_q,      blink_d;
    logic              load_q,       load_d;
    logic [TIME_W-1:0] load_time_q,  load_time_d;
    logic              editing_q,    editing_d;
    logic [1:0]        edit_field_q, edit_field_d;
    logic              mode_prev_q;

    // ------------------------------------------------------------------
    // Button events
    // ------------------------------------------------------------------
    logic w_mode_press;
    logic w_inc_step;
    logic w_dec_step;
    logic w_both_step;
    logic w_inc_apply;
    logic w_dec_apply;
    logic w_activity;
    logic w_unused_ms;

    assign w_mode_press = bus.btn_mode & ~mode_prev_q;
    assign w_both_step  = w_inc_step & w_dec_step;
    // Mode beats inc/dec; inc together with dec cancels out
    assign w_inc_apply  = w_inc_step & ~w_dec_step & ~w_mode_press;
    assign w_dec_apply  = w_dec_step & ~w_inc_step & ~w_mode_press;
    assign w_activity   = w_mode_press | w_inc_step | w_dec_step;
    // The live ms field is never needed; the load always carries 0 ms
    assign w_unused_ms  = ^bus.cur_time[MS_OFF +: MS_W];

    btn_repeat #(
        .HOLD_MS (HOLD_MS),
        .RPT_MS  (RPT_MS),
        .CNT_W   (CNT_W)
    ) u_inc_rpt (
        .kh_clk (kh_clk),
        .reset  (reset),
        .btn_i  (bus.btn_inc),
        .clr_i  (w_both_step),
        .step_o (w_inc_step)
    );

    btn_repeat #(
        .HOLD_MS (HOLD_MS),
        .RPT_MS  (RPT_MS),
        .CNT_W   (CNT_W)
    ) u_dec_rpt (
        .kh_clk (kh_clk),
        .reset  (reset),
        .btn_i  (bus.btn_dec),
        .clr_i  (w_both_step),
        .step_o (w_dec_step)
    );

    // ------------------------------------------------------------------
    // Selected field and its stepped value
    // ------------------------------------------------------------------
    logic [5:0] w_fld_cur;
    logic [5:0] w_fld_lim;
    logic [5:0] w_fld_new;

    always_comb begin
        w_fld_cur = ss_q;
        w_fld_lim = 6'(MS_MAX);
        case (state_q)
            ST_EDIT_HH: begin
                w_fld_cur = {1'b0, hh_q};
                w_fld_lim = 6'(HH_MAX);
            end
            ST_EDIT_MM: begin
                w_fld_cur = mm_q;
                w_fld_lim = 6'(MS_MAX);
            end
            default: begin
                w_fld_cur = ss_q;
                w_fld_lim = 6'(MS_MAX);
            end
        endcase
        w_fld_new = w_inc_apply ? wrap_inc(w_fld_cur, w_fld_lim)
                                : wrap_dec(w_fld_cur, w_fld_lim);
    end

    // ------------------------------------------------------------------
    // Next-state, shadow and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        hh_d        = hh_q;
        mm_d        = mm_q;
        ss_d        = ss_q;
        idle_d      = idle_q;

        case (state_q)
            ST_RUN: begin
                idle_d = '0;
                if (w_mode_press) begin
                    hh_d    = bus.cur_time[HH_OFF +: HH_W];
                    mm_d    = bus.cur_time[MM_OFF +: MM_W];
                    ss_d    = bus.cur_time[SS_OFF +: SS_W];
                    state_d = ST_EDIT_HH;
                end
            end
            ST_EDIT_HH, ST_EDIT_MM, ST_EDIT_SS: begin
                if (w_mode_press) begin
                    idle_d = '0;
                    case (state_q)
                        ST_EDIT_HH: state_d = ST_EDIT_MM;
                        ST_EDIT_MM: state_d = ST_EDIT_SS;
                        default:    state_d = ST_COMMIT;
                    endcase
                end else if (w_activity) begin
                    idle_d = '0;
                    if (w_inc_apply || w_dec_apply) begin
                        case (state_q)
                            ST_EDIT_HH: hh_d = w_fld_new[HH_W-1:0];
                            ST_EDIT_MM: mm_d = w_fld_new;
                            default:    ss_d = w_fld_new;
                        endcase
                    end
                end else if (idle_q == CNT_W'(TIMEOUT_MS - 1)) begin
                    idle_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                idle_d  = '0;
                state_d = ST_RUN;
            end
            default: begin
                idle_d  = '0;
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_comb begin
        load_d       = 1'b0;
        load_time_d  = load_time_q;
        editing_d    = 1'b0;
        edit_field_d = 2'd0;
        blink_d      = 1'b0;
        bcnt_d       = '0;

        case (state_d)
            ST_EDIT_HH: begin
                editing_d    = 1'b1;
                edit_field_d = 2'd1;
            end
            ST_EDIT_MM: begin
                editing_d    = 1'b1;
                edit_field_d = 2'd2;
            end
            ST_EDIT_SS: begin
                editing_d    = 1'b1;
                edit_field_d = 2'd3;
            end
            ST_COMMIT: begin
                load_d      = 1'b1;
                load_time_d = {hh_d, mm_d, ss_d, {MS_W{1'b0}}};
            end
            default: begin
                load_d = 1'b0;
            end
        endcase

        // Blink restarts from 0 on every state change, toggles while staying
        if (editing_d && (state_d == state_q)) begin
            if (bcnt_q == CNT_W'(BLINK_MS - 1)) begin
                blink_d = ~blink_q;
                bcnt_d  = '0;
            end else begin
                blink_d = blink_q;
                bcnt_d  = bcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            hh_q         <= '0;
            mm_q         <= '0;
            ss_q         <= '0;
            idle_q       <= '0;
            bcnt_q       <= '0;
            blink_q      <= 1'b0;
            load_q       <= 1'b0;
            load_time_q  <= '0;
            editing_q    <= 1'b0;
            edit_field_q <= 2'd0;
            // Reset to 1 so a mode button held through reset is not a press
            mode_prev_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            hh_q         <= hh_d;
            mm_q         <= mm_d;
            ss_q         <= ss_d;
            idle_q       <= idle_d;
            bcnt_q       <= bcnt_d;
            blink_q      <= blink_d;
            load_q       <= load_d;
            load_time_q  <= load_time_d;
            editing_q    <= editing_d;
            edit_field_q <= edit_field_d;
            mode_prev_q  <= bus.btn_mode;
        end
    end

    assign bus.load       = load_q;
    assign bus.load_time  = load_time_q;
    assign bus.editing    = editing_q;
    assign bus.edit_field = edit_field_q;
    assign bus.blink      = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_set_ctrl
//  Description : Self-checking bench for clock_set_ctrl. A behavioural model
//                tracks elapsed times and field values; a compare process
//                checks every output each cycle, and directed sequences pin
//                hand-computed load values, latencies and reset behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clock_set_ctrl;
    import clock24_pkg::*;

    localparam int HOLD = 500;
    localparam int RPT  = 100;
    localparam int TMO  = 10000;
    localparam int BLK  = 250;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(
        .HOLD_MS    (HOLD),
        .RPT_MS     (RPT),
        .TIMEOUT_MS (TMO),
        .BLINK_MS   (BLK)
    ) u_dut (
        .kh_clk (clk),
        .reset  (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pack(input int h, input int m, input int s);
        return (h << HH_OFF) | (m << MM_OFF) | (s << SS_OFF);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 run, 1..3 edit hh/mm/ss, 4 commit
    // ------------------------------------------------------------------
    int   m_phase, m_hh, m_mm, m_ss, m_idle, m_bt, m_ti, m_td;
    int   m_load_time;
    logic m_load, m_pm, m_pi, m_pd, m_ai, m_ad;

    always @(posedge clk or posedge rst) begin : model
        logic mp, ip, dp, si, sd;
        int   dlt;
        if (rst) begin
            m_phase = 0; m_hh = 0; m_mm = 0; m_ss = 0;
            m_idle = 0; m_bt = 0; m_ti = 0; m_td = 0;
            m_load = 1'b0; m_load_time = 0;
            m_pm = 1'b1; m_pi = 1'b1; m_pd = 1'b1;
            m_ai = 1'b0; m_ad = 1'b0;
        end else begin
            mp = bus.btn_mode & ~m_pm;
            ip = bus.btn_inc  & ~m_pi;
            dp = bus.btn_dec  & ~m_pd;
            m_pm = bus.btn_mode; m_pi = bus.btn_inc; m_pd = bus.btn_dec;

            if (ip) begin m_ai = 1'b1; m_ti = 0; end else if (bus.btn_inc) m_ti++;
            if (!bus.btn_inc) m_ai = 1'b0;
            if (dp) begin m_ad = 1'b1; m_td = 0; end else if (bus.btn_dec) m_td++;
            if (!bus.btn_dec) m_ad = 1'b0;
            si = bus.btn_inc && m_ai && (m_ti == 0 || (m_ti >= HOLD && (m_ti - HOLD) % RPT == 0));
            sd = bus.btn_dec && m_ad && (m_td == 0 || (m_td >= HOLD && (m_td - HOLD) % RPT == 0));
            if (si && sd) begin m_ti = 0; m_td = 0; end

            m_load = 1'b0;
            if (m_phase == 4) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (mp) begin
                    m_hh = int'(bus.cur_time[HH_OFF +: HH_W]);
                    m_mm = int'(bus.cur_time[MM_OFF +: MM_W]);
                    m_ss = int'(bus.cur_time[SS_OFF +: SS_W]);
                    m_phase = 1; m_idle = 0; m_bt = 0;
                end
            end else if (mp) begin
                m_phase++; m_idle = 0; m_bt = 0;
                if (m_phase == 4) begin
                    m_load = 1'b1;
                    m_load_time = pack(m_hh, m_mm, m_ss);
                end
            end else if (si || sd) begin
                m_idle = 0; m_bt++;
                if (si != sd) begin
                    dlt = si ? 1 : -1;
                    if (m_phase == 1)      m_hh = (m_hh + dlt + 24) % 24;
                    else if (m_phase == 2) m_mm = (m_mm + dlt + 60) % 60;
                    else                   m_ss = (m_ss + dlt + 60) % 60;
                end
            end else begin
                m_idle++;
                if (m_idle >= TMO) m_phase = 0;
                else m_bt++;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin : compare
        int ed;
        if (!rst && chk_en) begin
            ed = (m_phase >= 1 && m_phase <= 3) ? 1 : 0;
            chk("load",       int'(bus.load),       int'(m_load));
            chk("load_time",  int'(bus.load_time),  m_load_time);
            chk("editing",    int'(bus.editing),    ed);
            chk("edit_field", int'(bus.edit_field), ed ? m_phase : 0);
            chk("blink",      int'(bus.blink),      ed ? ((m_bt / BLK) % 2) : 0);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 mode, 1 inc, 2 dec; one-cycle press followed by one low cycle
    task automatic pulse(input int which);
        if (which == 0) bus.btn_mode = 1'b1;
        else if (which == 1) bus.btn_inc = 1'b1;
        else bus.btn_dec = 1'b1;
        tick(1);
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
        tick(1);
    endtask

    // Mode press in EDIT_SS; load must be seen right after the press edge
    task automatic commit(input string name, input int exp_time);
        int k;
        bus.btn_mode = 1'b1;
        tick(1);
        bus.btn_mode = 1'b0;
        k = 0;
        while (!bus.load && k < 4) begin
            tick(1);
            k++;
        end
        chk({name, "_latency"}, k, 0);
        chk({name, "_load"}, int'(bus.load), 1);
        chk({name, "_time"}, int'(bus.load_time), exp_time);
        chk({name, "_model"}, m_load_time, exp_time);
        tick(1);
        chk({name, "_load_drop"}, int'(bus.load), 0);
        chk({name, "_hold"}, int'(bus.load_time), exp_time);
        tick(1);
    endtask

    initial begin : stim
        int  c;
        logic saw_load;
        bus.btn_mode = 1'b1; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
        bus.cur_time = '0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk_en = 1'b1;
        tick(3);
        // Mode held through reset: no press
        chk("rst_load",       int'(bus.load),       0);
        chk("rst_load_time",  int'(bus.load_time),  0);
        chk("rst_editing",    int'(bus.editing),    0);
        chk("rst_edit_field", int'(bus.edit_field), 0);
        chk("rst_blink",      int'(bus.blink),      0);
        bus.btn_mode = 1'b0;
        tick(2);

        // Inc in RUN is ignored
        pulse(1);
        chk("run_inc_editing", int'(bus.editing), 0);

        // 10:20:30.555 -> 12:19:31.000
        bus.cur_time = {5'd10, 6'd20, 6'd30, 10'd555};
        pulse(0);
        chk("enter_field", int'(bus.edit_field), 1);
        chk("enter_editing", int'(bus.editing), 1);
        pulse(1); pulse(1);
        pulse(0);
        chk("mm_field", int'(bus.edit_field), 2);
        pulse(2);
        pulse(0);
        chk("ss_field", int'(bus.edit_field), 3);
        pulse(1);
        commit("basic", pack(12, 19, 31));

        // Wrap: hh 23+1, mm 59+1, ss 0-1
        bus.cur_time = {5'd23, 6'd59, 6'd0, 10'd0};
        pulse(0); pulse(1);
        pulse(0); pulse(1);
        pulse(0); pulse(2);
        commit("wrap_a", pack(0, 0, 59));

        // Wrap: hh 0-1, ss 59+1
        bus.cur_time = {5'd0, 6'd30, 6'd59, 10'd0};
        pulse(0); pulse(2);
        pulse(0); pulse(0); pulse(1);
        commit("wrap_b", pack(23, 30, 0));

        // Hold inc in EDIT_SS across edges N..N+800: steps at 0,500,600,700,800
        bus.cur_time = '0;
        pulse(0); pulse(0); pulse(0);
        bus.btn_inc = 1'b1;
        tick(801);
        bus.btn_inc = 1'b0;
        tick(1);
        commit("hold", pack(0, 0, 5));

        // Idle timeout: editing drops exactly TMO edges after entry, no load
        bus.cur_time = {5'd1, 6'd2, 6'd3, 10'd4};
        pulse(0);
        c = 1;
        saw_load = 1'b0;
        while (bus.editing && c < TMO + 10) begin
            tick(1);
            c++;
            if (bus.load) saw_load = 1'b1;
        end
        chk("timeout_cycles", c, TMO);
        chk("timeout_editing", int'(bus.editing), 0);
        chk("timeout_noload", int'(saw_load), 0);
        chk("timeout_lt_kept", int'(bus.load_time), pack(0, 0, 5));

        // Inc and dec together in EDIT_MM: no change
        bus.cur_time = {5'd5, 6'd10, 6'd15, 10'd999};
        pulse(0); pulse(0);
        bus.btn_inc = 1'b1; bus.btn_dec = 1'b1;
        tick(1);
        bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
        tick(1);
        pulse(0);
        commit("simul", pack(5, 10, 15));

        // Reset mid-EDIT_MM
        pulse(0); pulse(0); pulse(1);
        chk("pre_rst_field", int'(bus.edit_field), 2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("mid_rst_load",      int'(bus.load),       0);
        chk("mid_rst_editing",   int'(bus.editing),    0);
        chk("mid_rst_field",     int'(bus.edit_field), 0);
        chk("mid_rst_load_time", int'(bus.load_time),  0);
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
